// File: rtl/entry_vld_alloc.sv
// Per-entry valid allocator feeding a latch-based clock-gating stage; emits one-cycle
// enables only for entries whose valid bit changes. Optional: ENTRY_ALLOC_ROUND_ROBIN_EN.
module entry_vld_alloc #(
  parameter  int ENTRIES = 8,
  localparam int IDXW    = $clog2(ENTRIES),
  localparam int CNTW    = $clog2(ENTRIES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alloc_req,
  output logic               alloc_gnt,
  output logic [IDXW-1:0]    alloc_idx,
  input  logic               free_req,
  input  logic [IDXW-1:0]    free_idx,
  output logic [ENTRIES-1:0] ff_en_e1,
  output logic [ENTRIES-1:0] dvld,
  output logic [ENTRIES-1:0] entry_vld,
  output logic [CNTW-1:0]    count,
  output logic               full,
  output logic               empty,
  output logic               free_err
);

  logic [ENTRIES-1:0] vld_q;
  logic [ENTRIES-1:0] ff_en_q;
  logic [ENTRIES-1:0] dvld_q;
  logic [CNTW-1:0]    count_q;
  logic               free_err_q;

  logic               sel_found;
  logic [IDXW-1:0]    sel_idx;
  logic               free_legal;
  logic [ENTRIES-1:0] set_mask;
  logic [ENTRIES-1:0] clr_mask;
  logic [CNTW-1:0]    count_nxt;

  // Status derives from registered state only, so a same-cycle free never opens a grant.
  assign full      = (count_q == CNTW'(ENTRIES));
  assign empty     = (count_q == '0);
  assign alloc_gnt = alloc_req & ~full;
  assign alloc_idx = sel_idx;

`ifdef ENTRY_ALLOC_ROUND_ROBIN_EN
  logic [IDXW-1:0] rr_q;

  always_comb begin
    int j;
    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    sel_found = 1'b0;
    sel_idx   = '0;
    j         = 0;
    for (int k = 0; k < ENTRIES; k++) begin
      j = int'(rr_q) + k;
      if (j >= ENTRIES) j = j - ENTRIES;
      if (!sel_found && !vld_q[j]) begin
        sel_found = 1'b1;
        sel_idx   = IDXW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= '0;
    end else if (alloc_gnt) begin
      rr_q <= (alloc_idx == IDXW'(ENTRIES - 1)) ? '0 : alloc_idx + 1'b1;
    end
  end
`else
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!sel_found && !vld_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDXW'(i);
      end
    end
  end
`endif

  // Index match per entry also rejects out-of-range indices for non-power-of-two sizes.
  always_comb begin
    set_mask   = '0;
    clr_mask   = '0;
    free_legal = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (alloc_gnt && (alloc_idx == IDXW'(i))) set_mask[i] = 1'b1;
      if (free_req && (free_idx == IDXW'(i)) && vld_q[i]) begin
        clr_mask[i] = 1'b1;
        free_legal  = 1'b1;
      end
    end
  end

  always_comb begin
    count_nxt = count_q;
    case ({alloc_gnt, free_legal})
      2'b10:   count_nxt = count_q + 1'b1;
      2'b01:   count_nxt = count_q - 1'b1;
      default: count_nxt = count_q;
    endcase
  end

  // Granted and freed entries are always disjoint, so the masks never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      vld_q      <= '0;
      ff_en_q    <= '0;
      dvld_q     <= '0;
      count_q    <= '0;
      free_err_q <= 1'b0;
    end else begin
      vld_q   <= (vld_q & ~clr_mask) | set_mask;
      ff_en_q <= set_mask | clr_mask;
      dvld_q  <= (dvld_q & ~clr_mask) | set_mask;
      count_q <= count_nxt;
      if (free_req && !free_legal) free_err_q <= 1'b1;
    end
  end

  assign entry_vld = vld_q;
  assign ff_en_e1  = ff_en_q;
  assign dvld      = dvld_q;
  assign count     = count_q;
  assign free_err  = free_err_q;

endmodule
